demux_key_reg: RTL and testbench

//  Key-indexed stream demultiplexer: routes one valid/ready input beat to one of NR_KEY

---
 rtl/demux_key_reg_pkg.sv | 14 +
 rtl/demux_key_reg_slot.sv | 36 +++
 rtl/demux_key_reg.sv | 75 +++++++
 tb/tb_demux_key_reg.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/demux_key_reg_pkg.sv
// Shared defaults and helpers for the key-indexed stream demultiplexer.
package demux_key_reg_pkg;

  localparam int unsigned DEF_NR_KEY   = 2;
  localparam int unsigned DEF_KEY_LEN  = 1;
  localparam int unsigned DEF_DATA_LEN = 1;
  localparam int unsigned DEF_CNT_W    = 8;

  // Compared at 32 bits so that NR_KEY == 2**KEY_LEN does not truncate to zero.
  function automatic logic key_is_hit(input int unsigned key, input int unsigned nr_key);
    return key < nr_key;
  endfunction

endpackage

// File: rtl/demux_key_reg_slot.sv
// One-entry valid/data register for a single output channel.
module demux_key_reg_slot #(
  parameter int unsigned DATA_LEN = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_load,
  input  logic                i_ready,
  input  logic [DATA_LEN-1:0] i_data,
  output logic                o_valid,
  output logic [DATA_LEN-1:0] o_data
);

  logic                r_valid;
  logic [DATA_LEN-1:0] r_data;
  logic                w_pop;

  assign w_pop = r_valid & i_ready;

  // Load wins over pop: a simultaneous pop and load replaces the beat in place.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (w_pop) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/demux_key_reg.sv
// Key-indexed stream demux: one input beat routed to one of NR_KEY registered
// channels; out-of-range keys are accepted, dropped and counted.
module demux_key_reg
  import demux_key_reg_pkg::*;
#(
  parameter int unsigned NR_KEY   = DEF_NR_KEY,
  parameter int unsigned KEY_LEN  = DEF_KEY_LEN,
  parameter int unsigned DATA_LEN = DEF_DATA_LEN,
  parameter int unsigned CNT_W    = DEF_CNT_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_in_valid,
  output logic                       o_in_ready,
  input  logic [KEY_LEN-1:0]         i_in_key,
  input  logic [DATA_LEN-1:0]        i_in_data,
  output logic [NR_KEY-1:0]          o_out_valid,
  input  logic [NR_KEY-1:0]          i_out_ready,
  output logic [NR_KEY*DATA_LEN-1:0] o_out_data,
  output logic [CNT_W-1:0]           o_miss_cnt,
  output logic                       o_miss_pulse
);

  logic              w_hit;
  logic              w_slot_free;
  logic              w_accept;
  logic              w_miss_acc;
  logic [NR_KEY-1:0] w_load;
  logic [CNT_W-1:0]  r_miss_cnt;
  logic              r_miss_pulse;

  assign w_hit = key_is_hit(32'(i_in_key), NR_KEY);

  // A miss key matches no channel, so the slot stays "free" and misses never stall.
  always_comb begin
    w_slot_free = 1'b1;
    for (int i = 0; i < int'(NR_KEY); i++) begin
      if (i_in_key == KEY_LEN'(i)) w_slot_free = ~o_out_valid[i] | i_out_ready[i];
    end
  end

  assign o_in_ready = w_slot_free;
  assign w_accept   = i_in_valid & w_slot_free;
  assign w_miss_acc = w_accept & ~w_hit;

  for (genvar g = 0; g < int'(NR_KEY); g++) begin : g_slot
    assign w_load[g] = w_accept & w_hit & (i_in_key == KEY_LEN'(g));

    demux_key_reg_slot #(
      .DATA_LEN(DATA_LEN)
    ) u_slot (
      .clk    (clk),
      .rst    (rst),
      .i_load (w_load[g]),
      .i_ready(i_out_ready[g]),
      .i_data (i_in_data),
      .o_valid(o_out_valid[g]),
      .o_data (o_out_data[DATA_LEN*(g+1)-1 -: DATA_LEN])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_miss_cnt   <= '0;
      r_miss_pulse <= 1'b0;
    end else begin
      r_miss_pulse <= w_miss_acc;
      if (w_miss_acc && (r_miss_cnt != {CNT_W{1'b1}})) r_miss_cnt <= r_miss_cnt + CNT_W'(1);
    end
  end

  assign o_miss_cnt   = r_miss_cnt;
  assign o_miss_pulse = r_miss_pulse;

endmodule

// File: tb/tb_demux_key_reg.sv
// Directed and randomized checks for demux_key_reg (4-channel and 3-channel builds).
module tb_demux_key_reg;
  import demux_key_reg_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // DUT A: 4 channels, no misses possible
  logic        a_valid, a_ready;
  logic [1:0]  a_key;
  logic [7:0]  a_data;
  logic [3:0]  a_ov, a_ordy;
  logic [31:0] a_od;
  logic [7:0]  a_cnt;
  logic        a_pulse;

  // DUT B: 3 channels, key 3 is a miss, 2-bit counter
  logic        b_valid, b_ready;
  logic [1:0]  b_key;
  logic [7:0]  b_data;
  logic [2:0]  b_ov, b_ordy;
  logic [23:0] b_od;
  logic [1:0]  b_cnt;
  logic        b_pulse;

  demux_key_reg #(.NR_KEY(4), .KEY_LEN(2), .DATA_LEN(8), .CNT_W(8)) u_dut_a (
    .clk(clk), .rst(rst), .i_in_valid(a_valid), .o_in_ready(a_ready), .i_in_key(a_key),
    .i_in_data(a_data), .o_out_valid(a_ov), .i_out_ready(a_ordy), .o_out_data(a_od),
    .o_miss_cnt(a_cnt), .o_miss_pulse(a_pulse));

  demux_key_reg #(.NR_KEY(3), .KEY_LEN(2), .DATA_LEN(8), .CNT_W(2)) u_dut_b (
    .clk(clk), .rst(rst), .i_in_valid(b_valid), .o_in_ready(b_ready), .i_in_key(b_key),
    .i_in_data(b_data), .o_out_valid(b_ov), .i_out_ready(b_ordy), .o_out_data(b_od),
    .o_miss_cnt(b_cnt), .o_miss_pulse(b_pulse));

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  typedef struct {
    logic       valid;
    logic [1:0] key;
    logic [7:0] data;
    logic [3:0] ordy;
    logic       exp_rdy;
    logic [3:0] exp_ov;
    logic [7:0] exp_d;   // data of channel 'key' after the edge
  } vec_t;

  vec_t vecs[13];

  logic [3:0] mv;
  logic [7:0] md[4];

  initial begin
    // back-to-back keys 0..3, all consumers ready
    vecs[0]  = '{1'b1, 2'd0, 8'hA0, 4'b1111, 1'b1, 4'b0001, 8'hA0};
    vecs[1]  = '{1'b1, 2'd1, 8'hA1, 4'b1111, 1'b1, 4'b0010, 8'hA1};
    vecs[2]  = '{1'b1, 2'd2, 8'hA2, 4'b1111, 1'b1, 4'b0100, 8'hA2};
    vecs[3]  = '{1'b1, 2'd3, 8'hA3, 4'b1111, 1'b1, 4'b1000, 8'hA3};
    vecs[4]  = '{1'b0, 2'd3, 8'h00, 4'b1111, 1'b1, 4'b0000, 8'hA3};
    // channel 2 stalled, second beat waits, then pop+load on one edge
    vecs[5]  = '{1'b1, 2'd2, 8'h11, 4'b1011, 1'b1, 4'b0100, 8'h11};
    vecs[6]  = '{1'b1, 2'd2, 8'h22, 4'b1011, 1'b0, 4'b0100, 8'h11};
    vecs[7]  = '{1'b1, 2'd2, 8'h22, 4'b1111, 1'b1, 4'b0100, 8'h22};
    vecs[8]  = '{1'b0, 2'd2, 8'h00, 4'b1111, 1'b1, 4'b0000, 8'h22};
    // channel 1 stalled full does not block key 3
    vecs[9]  = '{1'b1, 2'd1, 8'h55, 4'b1101, 1'b1, 4'b0010, 8'h55};
    vecs[10] = '{1'b1, 2'd3, 8'h33, 4'b1101, 1'b1, 4'b1010, 8'h33};
    vecs[11] = '{1'b1, 2'd1, 8'h66, 4'b1101, 1'b0, 4'b0010, 8'h55};
    vecs[12] = '{1'b0, 2'd1, 8'h00, 4'b1111, 1'b1, 4'b0000, 8'h55};

    rst = 1'b1;
    a_valid = 1'b0; a_key = '0; a_data = '0; a_ordy = '1;
    b_valid = 1'b0; b_key = '0; b_data = '0; b_ordy = '1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_a_ov", 32'(a_ov), 32'h0);
    chk("rst_a_od", a_od, 32'h0);
    chk("rst_a_cnt", 32'(a_cnt), 32'h0);
    chk("rst_a_pulse", 32'(a_pulse), 32'h0);
    chk("rst_b_cnt", 32'(b_cnt), 32'h0);
    rst = 1'b0;

    for (int v = 0; v < 13; v++) begin
      a_valid = vecs[v].valid; a_key = vecs[v].key;
      a_data = vecs[v].data;   a_ordy = vecs[v].ordy;
      @(negedge clk);
      chk($sformatf("vec%0d_in_ready", v), 32'(a_ready), 32'(vecs[v].exp_rdy));
      @(posedge clk); #1;
      chk($sformatf("vec%0d_out_valid", v), 32'(a_ov), 32'(vecs[v].exp_ov));
      chk($sformatf("vec%0d_out_data", v), 32'(a_od[8*vecs[v].key +: 8]), 32'(vecs[v].exp_d));
    end
    a_valid = 1'b0;

    // misses on the 3-channel build: counter saturates at 3
    for (int n = 0; n < 5; n++) begin
      b_valid = 1'b1; b_key = 2'd3; b_data = 8'(n);
      @(negedge clk);
      chk($sformatf("miss%0d_in_ready", n), 32'(b_ready), 32'h1);
      @(posedge clk); #1;
      chk($sformatf("miss%0d_pulse", n), 32'(b_pulse), 32'h1);
      chk($sformatf("miss%0d_cnt", n), 32'(b_cnt), (n < 2) ? 32'(n + 1) : 32'h3);
      chk($sformatf("miss%0d_out_valid", n), 32'(b_ov), 32'h0);
    end
    b_valid = 1'b0;
    @(posedge clk); #1;
    chk("miss_idle_pulse", 32'(b_pulse), 32'h0);
    chk("miss_idle_cnt", 32'(b_cnt), 32'h3);
    chk("a_never_misses", 32'(a_cnt), 32'h0);

    // fill channels 0 and 1, then reset mid-stream
    a_ordy = 4'b0000;
    a_valid = 1'b1; a_key = 2'd0; a_data = 8'h10;
    @(posedge clk); #1;
    a_key = 2'd1; a_data = 8'h20;
    @(posedge clk); #1;
    chk("fill_out_valid", 32'(a_ov), 32'h3);
    a_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_out_valid", 32'(a_ov), 32'h0);
    chk("midrst_out_data", a_od, 32'h0);
    chk("midrst_b_cnt", 32'(b_cnt), 32'h0);
    chk("midrst_b_pulse", 32'(b_pulse), 32'h0);
    a_valid = 1'b1; a_key = 2'd0; a_data = 8'h77;
    @(posedge clk); #1;
    chk("postrst_out_valid", 32'(a_ov), 32'h1);
    chk("postrst_out_data", 32'(a_od[7:0]), 32'h77);
    a_valid = 1'b0; a_ordy = 4'b1111;
    @(posedge clk); #1;
    chk("drain_out_valid", 32'(a_ov), 32'h0);

    // randomized run against a depth-1 per-key model
    mv = '0;
    for (int k = 0; k < 4; k++) md[k] = '0;
    for (int c = 0; c < 10000; c++) begin
      logic       e_rdy;
      logic [31:0] e_d, m_d;
      a_valid = 1'($urandom_range(0, 1));
      a_key   = 2'($urandom_range(0, 3));
      a_data  = 8'($urandom);
      a_ordy  = 4'($urandom);
      e_rdy = ~mv[a_key] | a_ordy[a_key];
      @(negedge clk);
      chk("rand_in_ready", 32'(a_ready), 32'(e_rdy));
      @(posedge clk);
      for (int k = 0; k < 4; k++) begin
        if (a_valid && e_rdy && (a_key == 2'(k))) begin
          mv[k] = 1'b1; md[k] = a_data;
        end else if (mv[k] && a_ordy[k]) begin
          mv[k] = 1'b0;
        end
      end
      #1;
      e_d = '0; m_d = '0;
      for (int k = 0; k < 4; k++) begin
        if (mv[k]) begin
          e_d[8*k +: 8] = md[k];
          m_d[8*k +: 8] = a_od[8*k +: 8];
        end
      end
      chk("rand_out_valid", 32'(a_ov), 32'(mv));
      chk("rand_out_data", m_d, e_d);
    end
    chk("rand_no_miss", 32'(a_cnt), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
